// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with byte-wide register file, pointer writes and auto-increment reads
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         AW          = $clog2(DEPTH)
) (
    input  logic          system_clock,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
    } state_t;

    localparam logic [AW-1:0] PTR_ONE = 1;

    logic          scl_s1_q, scl_s2_q, scl_h_q;
    logic          sda_s1_q, sda_s2_q, sda_h_q;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic          ack_phase_q, ack_phase_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    regs_q [DEPTH];
    logic          reg_we;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_byte;

    assign scl_rise  =  scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q &  scl_h_q;
    assign start_det =  scl_s2_q &  scl_h_q & ~sda_s2_q &  sda_h_q;
    assign stop_det  =  scl_s2_q &  scl_h_q &  sda_s2_q & ~sda_h_q;
    assign rx_byte   = {shift_q[6:0], sda_s2_q};
    assign tx_byte   = regs_q[ptr_q];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;
        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'd0;
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            ack_phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_d = 1'b0;
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                    state_d = ST_ADDR_ACK;
                                end else begin
                                    busy_d  = 1'b0;
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                reg_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_q + PTR_ONE;
                                state_d     = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // First fall (end of bit 8) starts the ACK, the second one ends it.
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            shift_d     = 8'd0;
                            sda_oe_d    = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                shift_d  = tx_byte;
                                sda_oe_d = ~tx_byte[7];
                                state_d  = ST_RDATA;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    // The bit on the bus is always shift_q[7]; advance after the master samples it.
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            state_d     = ST_RDATA_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            sda_oe_d  = ~shift_q[7];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            ack_phase_d = 1'b1;
                            ptr_d       = ptr_q + PTR_ONE;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        shift_d     = tx_byte;
                        sda_oe_d    = ~tx_byte[7];
                        state_d     = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            // Synchronizers reset to the idle bus level so release does not fake an edge.
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_h_q     <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_h_q     <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            rd_data_q   <= 8'd0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'd0;
        end else begin
            scl_s1_q    <= scl_i;
            scl_s2_q    <= scl_s1_q;
            scl_h_q     <= scl_s2_q;
            sda_s1_q    <= sda_i;
            sda_s2_q    <= sda_s1_q;
            sda_h_q     <= sda_s2_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= regs_q[rd_addr];
            if (reg_we) regs_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_data   = rd_data_q;

endmodule
